// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core: one 512-bit block per 64/UNROLL+1 cycles,
// UNROLL rounds per clock, chaining either from the IV or from the previous digest.
module sha256_iter_core #(
  parameter int unsigned UNROLL  = 1,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         first,
  input  logic [511:0] block,
  output logic         ready,
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_iter_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] Step      = 6'(UNROLL);
  localparam logic [5:0] LastRound = 6'(64 - UNROLL);

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        round_q, round_d;
  logic [0:7][31:0]  v_q, v_d;      // working variables a..h
  logic [0:15][31:0] w_q, w_d;      // w_q[0] is W[t]
  logic [0:7][31:0]  h_q, h_d;      // chaining value H0..H7
  logic              first_q, first_d;
  logic              dv_q, dv_d;

  logic [0:7][31:0]  v_rnd;
  logic [0:15][31:0] w_rnd;

  // UNROLL rounds chained combinationally; the window always yields W[t+16] at its tail.
  always_comb begin : round_logic
    logic [31:0] t1, t2, w_new;
    t1    = '0;
    t2    = '0;
    w_new = '0;
    v_rnd = v_q;
    w_rnd = w_q;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      t1 = v_rnd[7] + big_sigma1(v_rnd[4]) + ((v_rnd[4] & v_rnd[5]) ^ (~v_rnd[4] & v_rnd[6]))
           + K[round_q + 6'(u)] + w_rnd[0];
      t2 = big_sigma0(v_rnd[0])
           + ((v_rnd[0] & v_rnd[1]) ^ (v_rnd[0] & v_rnd[2]) ^ (v_rnd[1] & v_rnd[2]));
      v_rnd = {t1 + t2, v_rnd[0:2], v_rnd[3] + t1, v_rnd[4:6]};
      w_new = small_sigma1(w_rnd[14]) + w_rnd[9] + small_sigma0(w_rnd[1]) + w_rnd[0];
      w_rnd = {w_rnd[1:15], w_new};
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    v_d     = v_q;
    w_d     = w_q;
    h_d     = h_q;
    first_d = first_q;
    dv_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRound;
          round_d = '0;
          w_d     = block;
          v_d     = first ? IV : h_q;
          first_d = first;
        end
      end
      StRound: begin
        v_d     = v_rnd;
        w_d     = w_rnd;
        round_d = round_q + Step;
        if (round_q == LastRound) begin
          state_d = StFinal;
        end
      end
      StFinal: begin
        // h_q stays untouched until here, so first=1 re-derives the IV as chain source.
        for (int i = 0; i < 8; i++) begin
          h_d[i] = (first_q ? IV[i] : h_q[i]) + v_q[i];
        end
        dv_d    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      round_q <= '0;
      v_q     <= '0;
      w_q     <= '0;
      h_q     <= IV;
      first_q <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      v_q     <= v_d;
      w_q     <= w_d;
      h_q     <= h_d;
      first_q <= first_d;
      dv_q    <= dv_d;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [255:0] digest_q, digest_d;

    always_comb begin
      digest_d = digest_q;
      if (state_q == StFinal) begin
        digest_d = h_d;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        digest_q <= IV;
      end else begin
        digest_q <= digest_d;
      end
    end

    assign digest = digest_q;
  end else begin : g_out_comb
    assign digest = h_q;
  end

  assign ready        = (state_q == StIdle);
  assign busy         = ~ready;
  assign digest_valid = dv_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
// Randomised bench for sha256_iter_core: known-answer vectors plus random chained blocks,
// each checked against a plain-arithmetic SHA-256 compression model.
module tb_sha256_iter_core;

  localparam int unsigned UNROLL = 1;
  localparam int unsigned LAT    = 64 / UNROLL + 1;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         first;
  logic [511:0] block;
  logic         ready;
  logic         busy;
  logic [255:0] digest;
  logic         digest_valid;

  sha256_iter_core #(
    .UNROLL (UNROLL),
    .OUT_REG(1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .first       (first),
    .block       (block),
    .ready       (ready),
    .busy        (busy),
    .digest      (digest),
    .digest_valid(digest_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  logic [255:0] h_model;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of one block from chaining value hin.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 64; i++) begin
      w[i] = w[i - 16] + (rotr(w[i - 15], 7) ^ rotr(w[i - 15], 18) ^ (w[i - 15] >> 3))
             + w[i - 7] + (rotr(w[i - 2], 17) ^ rotr(w[i - 2], 19) ^ (w[i - 2] >> 10));
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom;
    return r;
  endfunction

  // Called one time unit after an edge with the core idle; returns in the digest_valid cycle.
  task automatic run_block(input logic [511:0] blk, input bit fst, input bit noise,
                           input string tag);
    int n;
    logic [255:0] want;
    want = compress(fst ? IV : h_model, blk);
    check_eq({tag, "_ready_in"}, 256'(ready), 256'(1));
    start = 1'b1;
    first = fst;
    block = blk;
    @(posedge clk); #1;
    start = 1'b0;
    first = 1'($urandom);
    block = rand512();
    check_eq({tag, "_busy"}, 256'(busy), 256'(1));
    check_eq({tag, "_dv_low"}, 256'(digest_valid), 256'(0));
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (digest_valid) break;
      if (noise && (n == 2 || n == 10 || n == 30)) begin
        start = 1'b1;
        block = rand512();
        first = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, 256'(n), 256'(LAT));
    check_eq({tag, "_digest"}, digest, want);
    check_eq({tag, "_ready_out"}, 256'(ready), 256'(1));
    h_model = want;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      check_eq("hold_digest", digest, h_model);
      check_eq("hold_dv", 256'(digest_valid), 256'(0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int abort_cycles;
    reset_n = 1'b1;
    start   = 1'b0;
    first   = 1'b0;
    block   = '0;
    h_model = IV;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_ready", 256'(ready), 256'(1));
    check_eq("rst_busy", 256'(busy), 256'(0));
    check_eq("rst_dv", 256'(digest_valid), 256'(0));
    check_eq("rst_digest", digest, IV);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_block(ABC_BLK, 1'b1, 1'b0, "abc");
    check_eq("abc_kat", digest, ABC_DIGEST);
    idle(3);

    run_block(EMPTY_BLK, 1'b1, 1'b0, "empty");
    check_eq("empty_kat", digest, EMPTY_DIGEST);
    idle(2);

    run_block(TWO_BLK1, 1'b1, 1'b0, "two_a");
    run_block(TWO_BLK2, 1'b0, 1'b0, "two_b");
    check_eq("two_kat", digest, TWO_DIGEST);
    idle(1);

    run_block(ABC_BLK, 1'b1, 1'b1, "noise");
    check_eq("noise_kat", digest, ABC_DIGEST);
    idle(1);

    // Abort mid-compression, then chain with first=0 which must fall back to the IV.
    abort_cycles = (UNROLL == 1) ? 20 : int'(LAT / 2);
    pulses = 0;
    start = 1'b1;
    first = 1'b1;
    block = ABC_BLK;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < abort_cycles; i++) begin
      @(posedge clk); #1;
      if (digest_valid) pulses++;
    end
    reset_n = 1'b0;
    #1;
    check_eq("abort_ready", 256'(ready), 256'(1));
    check_eq("abort_busy", 256'(busy), 256'(0));
    check_eq("abort_digest", digest, IV);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (digest_valid) pulses++;
    end
    reset_n = 1'b1;
    check_eq("abort_pulses", 256'(pulses), 256'(0));
    h_model = IV;
    run_block(ABC_BLK, 1'b0, 1'b0, "abort_abc");
    check_eq("abort_kat", digest, ABC_DIGEST);

    for (int i = 0; i < 12; i++) begin
      run_block(rand512(), ($urandom_range(0, 3) == 0), 1'($urandom), "rand");
      idle($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
